// File: rtl/countdown_arbiter.sv
// countdown_arbiter
//
// Shares one down-counter among N_REQ requesters. Idle requesters are
// arbitrated round-robin; the winner's start value is loaded and counted
// down one step per clock to zero. A one-cycle done pulse is then returned
// to the owner and the counter is freed.
//
// Build option:
//   COUNTDOWN_ARB_FIXED_PRIO_EN  when defined, the lowest-index requester
//                                always wins and no round-robin pointer is
//                                kept. When undefined (default), the search
//                                starts one past the previous owner.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   req        in   [N_REQ]        request level per requester, held until done
//   load_val   in   [N_REQ*WIDTH]  start value per requester, slice i at i*WIDTH
//   grant      out  [N_REQ]        one-hot owner of the counter, zero when free
//   done       out  [N_REQ]        one-cycle completion pulse to the owner
//   ready      out  1              counter free (IDLE)
//   active_id  out  [ID_W]         current owner, or last owner when idle
//   q          out  [WIDTH]        current count value
//
// Handshake: a requester raises req[i] and keeps it high. While the counter
// is busy only the owner's req bit is looked at; dropping it before done
// aborts the count without a done pulse. done[i] is asserted for exactly one
// cycle, always together with grant[i], and grant clears the cycle after.
// The FSM state is kept in the signal `state` for probing.

module countdown_arbiter #(
  parameter int  N_REQ = 4,
  parameter int  WIDTH = 5,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] load_val,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   ready,
  output logic [ID_W-1:0]        active_id,
  output logic [WIDTH-1:0]       q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state;

  logic [ID_W-1:0]  search_base;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [N_REQ-1:0] win_onehot;
  logic [WIDTH-1:0] win_load;
  int               cand;

`ifdef COUNTDOWN_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always begins at requester 0.
  assign search_base = '0;
`else
  // Round-robin: the search begins one past the most recent owner.
  logic [ID_W-1:0] rr_ptr;
  assign search_base = rr_ptr;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] id);
    if (int'(id) == N_REQ - 1) return '0;
    return id + 1'b1;
  endfunction
`endif

  // First set req bit scanning search_base, search_base+1, ... mod N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(search_base) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[win_id] = 1'b1;
  end

  assign win_load = load_val[int'(win_id)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      done      <= '0;
      ready     <= 1'b1;
      active_id <= '0;
      q         <= '0;
`ifndef COUNTDOWN_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // With no request, q simply keeps its last value.
          if (win_found) begin
            state     <= S_COUNT;
            grant     <= win_onehot;
            active_id <= win_id;
            q         <= win_load;
            ready     <= 1'b0;
          end
        end

        S_COUNT: begin
          // Abort beats reaching zero: a dropped request never sees done.
          if (!req[active_id]) begin
            state  <= S_IDLE;
            grant  <= '0;
            ready  <= 1'b1;
`ifndef COUNTDOWN_ARB_FIXED_PRIO_EN
            rr_ptr <= next_idx(active_id);
`endif
          end else if (q == '0) begin
            state <= S_DONE;
            // grant is already the owner's one-hot vector.
            done  <= grant;
          end else begin
            q <= q - 1'b1;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          grant  <= '0;
          done   <= '0;
          ready  <= 1'b1;
`ifndef COUNTDOWN_ARB_FIXED_PRIO_EN
          rr_ptr <= next_idx(active_id);
`endif
        end

        default: begin
          state <= S_IDLE;
          grant <= '0;
          done  <= '0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_arbiter.sv
// Testbench for countdown_arbiter (N_REQ=4, WIDTH=5).
// Directed table vectors and hand-written corner sequences, with every
// cycle also compared against a transaction-level reference model.

module tb_countdown_arbiter;

  localparam int N = 4;
  localparam int W = 5;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] load_val;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           ready;
  logic [1:0]     active_id;
  logic [W-1:0]   q;

  always #5 clk = ~clk;

  countdown_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .load_val  (load_val),
    .grant     (grant),
    .done      (done),
    .ready     (ready),
    .active_id (active_id),
    .q         (q)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected grant order for the round-robin sequence.
  logic [1:0] exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Tracks who owns the timer, how much count is left and whether the
  // completion cycle is in progress; outputs follow directly from that.
  bit m_valid = 0;
  bit m_busy, m_fin;
  int m_owner, m_ptr, m_last, m_q;

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] lv);
    int start, c;
    bit found;
    if (r) begin
      m_valid = 1; m_busy = 0; m_fin = 0;
      m_owner = 0; m_ptr = 0; m_last = 0; m_q = 0;
    end else if (!m_valid) begin
      // nothing known before the first reset
    end else if (!m_busy) begin
`ifdef COUNTDOWN_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      found = 0;
      for (int i = 0; i < N; i++) begin
        c = (start + i) % N;
        if (!found && rq[c]) begin
          found = 1;
          m_busy = 1; m_owner = c; m_last = c;
          m_q = int'(lv[c*W +: W]);
        end
      end
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0; m_ptr = (m_owner + 1) % N;
    end else if (!rq[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % N;
    end else if (m_q == 0) begin
      m_fin = 1;
    end else begin
      m_q = m_q - 1;
    end
  endtask

  function automatic logic [15:0] model_outputs();
    logic [3:0] g, d;
    g = m_busy ? 4'(1 << m_owner) : 4'd0;
    d = m_fin  ? 4'(1 << m_owner) : 4'd0;
    return {g, d, !m_busy, 2'(m_last), 5'(m_q)};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: model consumes the inputs present at the edge, DUT outputs
  // are compared 1 time unit after the edge, then new inputs may be set.
  task automatic cycle();
    @(posedge clk);
    model_step(rst, req, load_val);
    #1;
    if (m_valid) check("model", {grant, done, ready, active_id, q}, model_outputs());
  endtask

  task automatic set_load(input int i, input int v);
    logic [W-1:0] vv;
    vv = v[W-1:0];
    load_val[i*W +: W] = vv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Wait (bounded) until the count reaches a value.
  task automatic wait_q(input int v, input string name);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cycle();
      if (q == W'(v)) hit = 1;
    end
    check(name, hit, 1);
  endtask

  task automatic wait_done(input string name);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cycle();
      if (done != '0) hit = 1;
    end
    check(name, hit, 1);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int id;       // requester
    int load;     // start value
    int lat;      // edges from request to done pulse
    int final_q;  // q once back in IDLE
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, eq;
    bit seq_ok, seen_done;
    int seen;
    logic [N-1:0] prev_grant;

    vecs[0] = '{id: 1, load: 3,  lat: 5,  final_q: 0};
    vecs[1] = '{id: 2, load: 0,  lat: 2,  final_q: 0};
    vecs[2] = '{id: 3, load: 31, lat: 33, final_q: 0};
    vecs[3] = '{id: 0, load: 10, lat: 12, final_q: 0};

    rst = 1'b1;
    req = '0;
    load_val = '0;

    // ---- reset state ----
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    check("rst_active_id", active_id, 0);
    check("rst_q", q, 0);

    // ---- single-requester table ----
    foreach (vecs[v]) begin
      req = '0;
      req[vecs[v].id] = 1'b1;
      set_load(vecs[v].id, vecs[v].load);
      cycle();
      n = 1;
      check("tbl_grant", grant, 1 << vecs[v].id);
      check("tbl_load", q, vecs[v].load);
      check("tbl_ready_busy", ready, 0);
      // load_val changes after the grant must not matter
      set_load(vecs[v].id, 7);
      seq_ok = 1;
      seen_done = 0;
      while (!seen_done && n < 60) begin
        cycle();
        n++;
        eq = vecs[v].load - (n - 1);
        if (eq < 0) eq = 0;
        if (q !== W'(eq)) seq_ok = 0;
        if (done != '0) seen_done = 1;
      end
      check("tbl_q_seq", seq_ok, 1);
      check("tbl_latency", n, vecs[v].lat);
      check("tbl_done_vec", done, 1 << vecs[v].id);
      check("tbl_grant_at_done", grant, 1 << vecs[v].id);
      req = '0;
      cycle();
      check("tbl_ready_after", ready, 1);
      check("tbl_grant_after", grant, 0);
      check("tbl_done_after", done, 0);
      check("tbl_final_q", q, vecs[v].final_q);
    end

    // ---- round-robin with all requesters held ----
    do_reset();
`ifdef COUNTDOWN_ARB_FIXED_PRIO_EN
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    for (int i = 0; i < N; i++) set_load(i, 1);
    req = '1;
    prev_grant = '0;
    seen = 0;
    for (int i = 0; i < 80 && seen < 5; i++) begin
      cycle();
      if (grant != '0 && prev_grant == '0 && exp_q.size() > 0) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("rr_order", active_id, e);
        check("rr_grant_onehot", grant, 1 << e);
        seen++;
      end
      prev_grant = grant;
    end
    check("rr_all_seen", exp_q.size(), 0);
    req = '0;
    cycle();
    cycle();

    // ---- abort mid-count, pending requester takes over ----
    do_reset();
    set_load(0, 10);
    set_load(1, 2);
    req = 4'b0001;
    wait_q(6, "abort_reach_q6");
    req = 4'b0010;
    cycle();
    check("abort_grant", grant, 0);
    check("abort_done", done, 0);
    check("abort_q_hold", q, 6);
    check("abort_ready", ready, 1);
    cycle();
    check("abort_next_grant", grant, 4'b0010);
    check("abort_next_id", active_id, 1);
    check("abort_next_q", q, 2);
    wait_done("abort_next_done_seen");
    check("abort_next_done", done, 4'b0010);
    req = '0;
    cycle();
    cycle();

    // ---- reset mid-count ----
    set_load(3, 8);
    req = 4'b1000;
    wait_q(4, "rstmid_reach_q4");
    rst = 1'b1;
    cycle();
    check("rstmid_grant", grant, 0);
    check("rstmid_done", done, 0);
    check("rstmid_q", q, 0);
    check("rstmid_ready", ready, 1);
    check("rstmid_active_id", active_id, 0);
    rst = 1'b0;
    req = 4'b1001;
    set_load(0, 2);
    cycle();
    check("rstmid_rr_from0", grant, 4'b0001);
    req = '0;
    cycle();
    cycle();

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, N - 1);
        req[b] = ~req[b];
      end
      if ($urandom_range(0, 1) == 0) begin
        int b;
        b = $urandom_range(0, N - 1);
        set_load(b, ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 6));
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    req = '0;
    cycle();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_arbiter.md
Name: countdown_arbiter

Overview:
- Shares one down-counter among N_REQ requesters; each requester supplies its own start value.
- Arbitrates round-robin, loads the winner's value, and counts down one step per clock to zero.
- Returns a one-cycle done pulse to the owner, then frees the counter.
- Sits between client FSMs needing delay timers and the single timer resource, replacing per-client counters.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 5, counter and load-value width in bits
- ID_W, $clog2(N_REQ), width of the owner index (derived, not overridden)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- req  input  N_REQ  per-requester request level; held high until done
- load_val  input  N_REQ*WIDTH  start value per requester; slice i = bits [i*WIDTH +: WIDTH]
- grant  output  N_REQ  one-hot owner of the counter; all zero when not owned
- done  output  N_REQ  one-cycle completion pulse to the owner
- ready  output  1  high in IDLE (counter free)
- active_id  output  ID_W  index of current owner; last owner when idle
- q  output  WIDTH  current count value

Behaviour:
- Reset values: state=IDLE, grant=0, done=0, ready=1, active_id=0, q=0, rr_ptr=0. Reset overrides everything, including mid-count.
- IDLE:
  - ready=1.
  - If any req bit is set, pick the winner k as the first set bit searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - Next cycle: grant[k]=1, active_id=k, q=load_val[k] (sampled in the IDLE cycle), state=COUNT, ready=0.
  - No req: remain in IDLE, q holds.
- COUNT:
  - If req[active_id] is high and q!=0: q<=q-1.
  - If req[active_id] is high and q==0: state=DONE.
  - If req[active_id] is low (abort): state=IDLE, grant=0, no done pulse, rr_ptr<=active_id+1 mod N_REQ, q holds its value.
  - Abort takes priority over q==0.
- DONE:
  - Single cycle: done[active_id]=1, grant still asserted.
  - Next cycle: state=IDLE, grant=0, done=0, rr_ptr<=active_id+1 mod N_REQ.
- Latency: req[k] first high in IDLE cycle t with load_val L gives grant at t+1 (q=L), q=0 at t+1+L, done at t+2+L, ready at t+3+L.
  - A new grant can appear at t+4+L.
  - L=0 gives done at t+2.
- Requests from non-owners are ignored while busy; they must stay high to be considered in IDLE.
- Changes to load_val after the grant cycle have no effect.
- q never wraps: decrement occurs only when q!=0.
- grant and done are always one-hot or zero. done is only ever asserted with the matching grant bit.

Optional Feature:
- Macro: COUNTDOWN_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index set req bit wins. rr_ptr is not implemented and the arbitration search always starts at 0.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then req=4'b0010, load_val[1]=3 → grant=4'b0010 next cycle, q sequence 3,2,1,0, done[1] pulse one cycle after q=0, ready returns one cycle later.
- req=4'b1111 held continuously, all load_val=1 → grants in order 0,1,2,3,0. With COUNTDOWN_ARB_FIXED_PRIO_EN defined, index 0 is granted every time.
- req[2] with load_val=0 → grant then done[2] two cycles after the request, q stays 0.
- req[0] with load_val=10, drop req[0] when q=6 → grant clears next cycle, done never pulses, q holds 6, next pending requester (e.g. req[1]) is granted from IDLE.
- Assert rst while q=4 in COUNT → next cycle grant=0, done=0, q=0, ready=1, and a subsequent arbitration starts from index 0.
- req[3] with load_val=31 (max) → exactly 31 decrements, no wrap, done[3] pulse, q remains 0 afterwards.
